// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential RISC-V M-extension divider:
// op encodings, FSM states and the signed-overflow dividend constant.
package seq_divider_pkg;

  localparam logic [1:0] DIV_OP  = 2'b00;
  localparam logic [1:0] DIVU_OP = 2'b01;
  localparam logic [1:0] REM_OP  = 2'b10;
  localparam logic [1:0] REMU_OP = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    SIGN = 2'b10,
    DONE = 2'b11
  } state_e;

  localparam logic [31:0] DIV_OVF_DIVIDEND = 32'h8000_0000;

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  function automatic logic op_is_rem(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Request/response bundle between the core and the divider.
// master = requesting core, slave = divider.
interface seq_divider_if #(parameter int DATA_WIDTH = 32);
  logic                  start_i;
  logic [1:0]            op_i;
  logic [DATA_WIDTH-1:0] dividend_i;
  logic [DATA_WIDTH-1:0] divisor_i;
  logic                  ready_o;
  logic                  valid_o;
  logic [DATA_WIDTH-1:0] result_o;
  logic                  div_by_zero_o;

  modport master (
    output start_i, op_i, dividend_i, divisor_i,
    input  ready_o, valid_o, result_o, div_by_zero_o
  );

  modport slave (
    input  start_i, op_i, dividend_i, divisor_i,
    output ready_o, valid_o, result_o, div_by_zero_o
  );
endinterface

// File: rtl/seq_divider_div_step.sv
// One combinational radix-2 restoring division step on unsigned magnitudes.
module div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem_i,
  input  logic [W-1:0] quot_i,
  input  logic [W-1:0] divisor_i,
  output logic [W-1:0] rem_o,
  output logic [W-1:0] quot_o
);
  logic [W:0] shifted;
  logic [W:0] diff;

  always_comb begin
    shifted = {rem_i, quot_i[W-1]};
    diff    = shifted - {1'b0, divisor_i};
    // Borrow out of the W+1-bit subtract means shifted < divisor: restore.
    if (!diff[W]) begin
      rem_o  = diff[W-1:0];
      quot_o = {quot_i[W-2:0], 1'b1};
    end else begin
      rem_o  = shifted[W-1:0];
      quot_o = {quot_i[W-2:0], 1'b0};
    end
  end
endmodule

// File: rtl/seq_divider.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Define SEQ_DIVIDER_EARLY_OUT_EN to bypass RUN for divide-by-zero and signed overflow.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 5
) (
  input  logic        clk,
  input  logic        reset,
  seq_divider_if.slave bus
);
  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] rem_q, quot_q, dvsr_q, result_q;
  logic [DATA_WIDTH-1:0] step_rem, step_quot;
  logic [DATA_WIDTH-1:0] a_mag, b_mag, q_fix, r_fix;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic                  is_rem_q, qneg_q, rneg_q, dbz_q, dbz_out_q;
  logic                  accept, a_neg, b_neg, dvsr_zero, early;

  assign accept    = bus.start_i && (state_q == IDLE || state_q == DONE);
  assign a_neg     = op_is_signed(bus.op_i) & bus.dividend_i[DATA_WIDTH-1];
  assign b_neg     = op_is_signed(bus.op_i) & bus.divisor_i[DATA_WIDTH-1];
  assign a_mag     = a_neg ? -bus.dividend_i : bus.dividend_i;
  assign b_mag     = b_neg ? -bus.divisor_i  : bus.divisor_i;
  assign dvsr_zero = (bus.divisor_i == '0);

`ifdef SEQ_DIVIDER_EARLY_OUT_EN
  localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  logic ovf;
  assign ovf   = op_is_signed(bus.op_i) && (bus.dividend_i == MIN_NEG) && (&bus.divisor_i);
  assign early = dvsr_zero | ovf;
`else
  assign early = 1'b0;
`endif

  div_step #(.W(DATA_WIDTH)) u_step (
    .rem_i     (rem_q),
    .quot_i    (quot_q),
    .divisor_i (dvsr_q),
    .rem_o     (step_rem),
    .quot_o    (step_quot)
  );

  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = early ? SIGN : RUN;
      RUN:  if (cnt_q == '0) state_d = SIGN;
      SIGN: state_d = DONE;
      DONE: state_d = accept ? (early ? SIGN : RUN) : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.ready_o = 1'b0;
    bus.valid_o = 1'b0;
    case (state_q)
      IDLE: bus.ready_o = 1'b1;
      DONE: begin
        bus.ready_o = 1'b1;
        bus.valid_o = 1'b1;
      end
      default: ;
    endcase
  end

  // Divide-by-zero quotient stays all-ones; remainder sign fix restores the dividend.
  assign q_fix = dbz_q  ? '1      : (qneg_q ? -quot_q : quot_q);
  assign r_fix = rneg_q ? -rem_q  : rem_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rem_q     <= '0;
      quot_q    <= '0;
      dvsr_q    <= '0;
      cnt_q     <= '0;
      is_rem_q  <= 1'b0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      dbz_q     <= 1'b0;
      result_q  <= '0;
      dbz_out_q <= 1'b0;
    end else if (accept) begin
      is_rem_q <= op_is_rem(bus.op_i);
      dvsr_q   <= b_mag;
      qneg_q   <= a_neg ^ b_neg;
      rneg_q   <= a_neg;
      dbz_q    <= dvsr_zero;
      cnt_q    <= CNT_WIDTH'(DATA_WIDTH - 1);
      rem_q    <= '0;
      quot_q   <= a_mag;
`ifdef SEQ_DIVIDER_EARLY_OUT_EN
      if (dvsr_zero) begin
        quot_q <= '1;
        rem_q  <= a_mag;
      end else if (ovf) begin
        quot_q <= MIN_NEG;
      end
`endif
    end else if (state_q == RUN) begin
      rem_q  <= step_rem;
      quot_q <= step_quot;
      if (cnt_q != '0) cnt_q <= cnt_q - CNT_WIDTH'(1);
    end else if (state_q == SIGN) begin
      result_q  <= is_rem_q ? r_fix : q_fix;
      dbz_out_q <= dbz_q;
    end
  end

  assign bus.result_o      = result_q;
  assign bus.div_by_zero_o = dbz_out_q;
endmodule
